// File: rtl/eve_rng_scheduler.sv
// eve_rng_scheduler: 36-bit xor-rotate generator shared by NREQ requesters
// through a round-robin arbiter, with warm-up after reset/reseed.
// Ports: clk, reset (sync, active-high), pe_id (default-seed source),
//   reseed/seed_in (load new seed), req (level requests),
//   grant (registered one-hot), rnd_valid/rnd_data (delivered word),
//   busy (warming up), zero_recover (lock-up recovery pulse).
module eve_rng_scheduler #(
    parameter int NREQ   = 4,
    parameter int WARMUP = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      pe_id,
    input  logic            reseed,
    input  logic [35:0]     seed_in,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic            rnd_valid,
    output logic [35:0]     rnd_data,
    output logic            busy,
    output logic            zero_recover
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] ST_WARMUP = 1'b0;
    localparam logic [0:0] ST_SERVE  = 1'b1;

    // State entered after reset or reseed.
    localparam logic [0:0] ST_INIT = (WARMUP == 0) ? ST_SERVE : ST_WARMUP;
    localparam logic [7:0] W_LAST  = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);

    logic [0:0]    state;
    logic [35:0]   s;
    logic [7:0]    cnt;
    logic [PW-1:0] ptr;

    logic [35:0]   d;
    logic [35:0]   s_next;
    logic          s_zero;
    logic [35:0]   s_adv;

    logic [PW-1:0] cand;
    logic [PW-1:0] pick;
    logic          found;

    assign d      = {pe_id[3:0], pe_id, pe_id, pe_id, pe_id};
    assign s_next = {s[0], s[35:1]} ^ s;
    // An all-zero state is a fixed point; fall back to the default seed.
    assign s_zero = (s_next == 36'd0);
    assign s_adv  = s_zero ? d : s_next;
    assign busy   = (state == ST_WARMUP);

    // Round-robin search starting just after the last granted index.
    always_comb begin
        cand  = '0;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PW'((int'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_INIT;
            s            <= d;
            cnt          <= 8'd0;
            ptr          <= PW'(NREQ - 1);
            grant        <= '0;
            rnd_valid    <= 1'b0;
            rnd_data     <= 36'd0;
            zero_recover <= 1'b0;
        end else if (reseed) begin
            state        <= ST_INIT;
            s            <= (seed_in == 36'd0) ? d : seed_in;
            cnt          <= 8'd0;
            grant        <= '0;
            rnd_valid    <= 1'b0;
            zero_recover <= 1'b0;
        end else begin
            grant        <= '0;
            rnd_valid    <= 1'b0;
            zero_recover <= 1'b0;
            if (state == ST_WARMUP) begin
                s            <= s_adv;
                zero_recover <= s_zero;
                cnt          <= cnt + 8'd1;
                if (cnt == W_LAST) begin
                    state <= ST_SERVE;
                end
            end else if (found) begin
                grant        <= NREQ'(1) << pick;
                rnd_valid    <= 1'b1;
                rnd_data     <= s;
                s            <= s_adv;
                zero_recover <= s_zero;
                ptr          <= pick;
            end
        end
    end

endmodule

// File: tb/tb_eve_rng_scheduler.sv
// Testbench for eve_rng_scheduler: one WARMUP=0 and one WARMUP=8 instance,
// table-driven arbitration vectors plus directed multi-cycle sequences.
module tb_eve_rng_scheduler;

    logic        clk = 1'b0;
    logic [7:0]  pe_id = 8'h01;

    logic        r0, rs0, rv0, bz0, zr0;
    logic [35:0] sd0, rd0;
    logic [3:0]  rq0, g0;

    logic        r8, rs8, rv8, bz8, zr8;
    logic [35:0] sd8, rd8;
    logic [3:0]  rq8, g8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    eve_rng_scheduler #(.NREQ(4), .WARMUP(0)) u0 (
        .clk(clk), .reset(r0), .pe_id(pe_id), .reseed(rs0),
        .seed_in(sd0), .req(rq0), .grant(g0), .rnd_valid(rv0),
        .rnd_data(rd0), .busy(bz0), .zero_recover(zr0)
    );

    eve_rng_scheduler #(.NREQ(4), .WARMUP(8)) u8 (
        .clk(clk), .reset(r8), .pe_id(pe_id), .reseed(rs8),
        .seed_in(sd8), .req(rq8), .grant(g8), .rnd_valid(rv8),
        .rnd_data(rd8), .busy(bz8), .zero_recover(zr8)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_grant;
    } arb_vec_t;

    arb_vec_t tbl[12];

    localparam logic [35:0] DSEED = 36'h101010101;

    function automatic logic [35:0] gen_pow(input int n);
        logic [35:0] v;
        logic [35:0] nx;
        v = DSEED;
        for (int i = 0; i < n; i++) begin
            nx = {v[0], v[35:1]} ^ v;
            v  = (nx == 36'd0) ? DSEED : nx;
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [35:0] act,
                       input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0010};
        tbl[2]  = '{4'b1111, 4'b0100};
        tbl[3]  = '{4'b1111, 4'b1000};
        tbl[4]  = '{4'b1111, 4'b0001};
        tbl[5]  = '{4'b1010, 4'b0010};
        tbl[6]  = '{4'b1010, 4'b1000};
        tbl[7]  = '{4'b1010, 4'b0010};
        tbl[8]  = '{4'b0000, 4'b0000};
        tbl[9]  = '{4'b0100, 4'b0100};
        tbl[10] = '{4'b1001, 4'b1000};
        tbl[11] = '{4'b1001, 4'b0001};

        r0 = 1'b1; rs0 = 1'b0; sd0 = '0; rq0 = '0;
        r8 = 1'b1; rs8 = 1'b0; sd8 = '0; rq8 = '0;
        step();
        step();

        chk("rst_grant0", 36'(g0), 36'd0);
        chk("rst_valid0", 36'(rv0), 36'd0);
        chk("rst_data0", rd0, 36'd0);
        chk("rst_zr0", 36'(zr0), 36'd0);
        chk("rst_busy0", 36'(bz0), 36'd0);
        chk("rst_busy8", 36'(bz8), 36'd1);
        chk("rst_grant8", 36'(g8), 36'd0);

        // Release both; cycle 0 starts now.
        r0 = 1'b0; r8 = 1'b0;
        rq0 = 4'b0001; rq8 = 4'b0001;
        chk("wu_busy_c0", 36'(bz8), 36'd1);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("wu_busy_c%0d", k), 36'(bz8), 36'(k < 8));
            chk($sformatf("wu_grant_c%0d", k), 36'(g8),
                (k == 9) ? 36'd1 : 36'd0);
            if (k == 1) begin
                chk("seq_d0", rd0, 36'h101010101);
                chk("seq_g0", 36'(g0), 36'd1);
                chk("seq_v0", 36'(rv0), 36'd1);
            end else if (k == 2) begin
                chk("seq_d1", rd0, 36'h981818181);
                chk("seq_g1", 36'(g0), 36'd1);
                rq0 = 4'b0000;
            end else if (k == 3) begin
                chk("hold_g", 36'(g0), 36'd0);
                chk("hold_v", 36'(rv0), 36'd0);
                chk("hold_d", rd0, 36'h981818181);
            end
        end
        chk("wu_data8", rd8, gen_pow(8));
        chk("wu_valid8", 36'(rv8), 36'd1);
        rq8 = 4'b0000;

        // Arbitration table from a fresh pointer.
        r0 = 1'b1;
        step();
        r0 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rq0 = tbl[i].req;
            step();
            chk($sformatf("arb%0d_grant", i), 36'(g0),
                36'(tbl[i].exp_grant));
            chk($sformatf("arb%0d_valid", i), 36'(rv0),
                36'(|tbl[i].exp_grant));
        end

        // Lock-up recovery on an all-ones seed.
        rs0 = 1'b1; sd0 = 36'hFFFFFFFFF; rq0 = 4'b0001;
        step();
        chk("rsd_nogrant", 36'(g0), 36'd0);
        rs0 = 1'b0;
        step();
        chk("zr_data", rd0, 36'hFFFFFFFFF);
        chk("zr_pulse", 36'(zr0), 36'd1);
        step();
        chk("zr_after", rd0, 36'h101010101);
        chk("zr_clear", 36'(zr0), 36'd0);

        // Zero seed falls back to the default seed (no warm-up).
        rs0 = 1'b1; sd0 = 36'd0;
        step();
        chk("rz0_nogrant", 36'(g0), 36'd0);
        rs0 = 1'b0;
        step();
        chk("rz0_d0", rd0, 36'h101010101);
        step();
        chk("rz0_d1", rd0, 36'h981818181);
        rq0 = 4'b0000;

        // Zero seed with warm-up.
        rs8 = 1'b1; sd8 = 36'd0; rq8 = 4'b0001;
        step();
        chk("rz8_nogrant", 36'(g8), 36'd0);
        chk("rz8_busy", 36'(bz8), 36'd1);
        rs8 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("rz8_grant_c%0d", k), 36'(g8),
                (k == 9) ? 36'd1 : 36'd0);
        end
        chk("rz8_data", rd8, gen_pow(8));
        rq8 = 4'b0000;

        // Reset in the middle of serving.
        rq0 = 4'b1111;
        step();
        step();
        r0 = 1'b1;
        step();
        chk("mrst_grant", 36'(g0), 36'd0);
        chk("mrst_valid", 36'(rv0), 36'd0);
        r0 = 1'b0;
        step();
        chk("mrst_first", 36'(g0), 36'd1);
        chk("mrst_data", rd0, 36'h101010101);
        rq0 = 4'b0000;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eve_rng_scheduler.md
EVE_RNG_SCHEDULER -- requirements
Module: eve_rng_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter WARMUP, default 8: generator cycles discarded after reset/reseed, 0..255.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pe_id  input  8  PE identifier, source of default seed.
REQ-006 SHALL have port reseed  input  1  single-cycle reseed strobe.
REQ-007 SHALL have port seed_in  input  36  seed value loaded on reseed.
REQ-008 SHALL have port req  input  NREQ  per-requester level request.
REQ-009 SHALL have port grant  output  NREQ  registered one-hot grant, one cycle wide.
REQ-010 SHALL have port rnd_valid  output  1  high in the cycle rnd_data is delivered.
REQ-011 SHALL have port rnd_data  output  36  random word for the granted requester.
REQ-012 SHALL have port busy  output  1  high while in WARMUP state.
REQ-013 SHALL have port zero_recover  output  1  one-cycle pulse when lock-up recovery fires.

Function
REQ-014 SHALL hold 36-bit generator state S; next(S) = {S[0], S[35:1]} XOR S.
REQ-015 SHALL define default seed D = {pe_id[3:0], pe_id, pe_id, pe_id, pe_id}.
REQ-016 SHALL implement FSM states WARMUP and SERVE only.
REQ-017 WARMUP: S advances every cycle, counter counts WARMUP advances, then enters SERVE; no grants; busy=1.
REQ-018 WARMUP=0: FSM SHALL enter SERVE directly, with busy never asserted.
REQ-019 SERVE: if any req bit is set in cycle N, SHALL in cycle N+1 drive grant one-hot, rnd_valid=1, rnd_data=S sampled at N, and S SHALL advance once at that edge.
REQ-020 SERVE, no req: S SHALL hold, grant=0, rnd_valid=0; rnd_data SHALL hold its last value.
REQ-021 Arbitration SHALL be round-robin: search starts at (last granted index + 1) mod NREQ; pointer updates only on a grant.
REQ-022 At most one grant per cycle; a requester SHALL be granted again only after every other active requester has been granted.
REQ-023 If next(S) == 0 at any advance, S SHALL load D instead and zero_recover SHALL pulse in the following cycle.
REQ-024 reseed in SERVE or WARMUP: at next edge, S SHALL load seed_in, or D if seed_in == 0; the WARMUP counter SHALL clear and the FSM SHALL enter WARMUP (SERVE if WARMUP=0).
REQ-025 req in a reseed cycle SHALL be ignored (no grant in N+1); the RR pointer SHALL be kept.
REQ-026 reseed and reset together: reset SHALL win.

Reset
REQ-027 On reset: S=D, RR pointer=NREQ-1 (requester 0 highest priority first), counter=0, FSM=WARMUP (SERVE if WARMUP=0).
REQ-028 On reset: grant=0, rnd_valid=0, rnd_data=0, zero_recover=0; busy=1 unless WARMUP=0.
REQ-029 Reset mid-grant SHALL drop the grant the following cycle; no partially delivered word.

Verification
REQ-030 WARMUP=0, pe_id=0x01, req=0001 held -> successive rnd_data 0x101010101, then 0x981818181, one per cycle, grant=0001.
REQ-031 WARMUP=8, reset then req=0001 from first cycle -> busy=1 for 8 cycles, first grant on cycle 9 after reset release, no grant earlier.
REQ-032 NREQ=4, req=1111 held -> grants 0001,0010,0100,1000,0001; req=1010 -> alternating 0010,1000.
REQ-033 WARMUP=0, pe_id=0x01, reseed with seed_in=0xFFFFFFFFF, req=0001 -> rnd_data 0xFFFFFFFFF, zero_recover pulses, next rnd_data 0x101010101.
REQ-034 reseed with seed_in=0 while req=0001 -> no grant the next cycle; S reloaded to D; after warm-up the sequence matches REQ-030 from D.
REQ-035 reset asserted in a cycle with req=1111 in SERVE -> grant=0, rnd_valid=0 next cycle; the first grant after release goes to requester 0.
